// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, stage tap offsets and FSM states for the FFT sequencer
package fft_pkg;

  localparam int LOG2N    = 4;
  localparam int N        = 1 << LOG2N;
  localparam int MULT_LAT = 2;
  localparam int TOT_LAT  = 23;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Ce cycles a sample spends in stage s: SDF delay line plus twiddle multiplier.
  function automatic int stage_dly(int s, int log2n, int mult_lat);
    return ((1 << log2n) >> (s + 1)) + mult_lat;
  endfunction

  function automatic int stage_off(int s, int log2n, int mult_lat);
    int acc;
    acc = 0;
    for (int j = 0; j < s; j++) acc += stage_dly(j, log2n, mult_lat);
    return acc;
  endfunction

endpackage

// File: rtl/fft_stage_cnt.sv
// rtl/fft_stage_cnt.sv - per-stage sample counter driving butterfly enable and twiddle index
module fft_stage_cnt #(
  parameter int STAGE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       active,
  output logic       bf_en,
  output logic [2:0] tw_idx
);

  // Twiddle index is the position within the fill half, scaled to W16 units.
  localparam logic [3:0] TW_MASK = 4'((8 >> STAGE) - 1);

  logic [3:0] c;
  logic [2:0] tw_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
    end else if (ce && active) begin
      c <= c + 4'd1;
    end
  end

  assign bf_en   = active & c[3-STAGE];
  assign tw_full = 3'((c & TW_MASK) << STAGE);
  assign tw_idx  = (active && !bf_en) ? tw_full : 3'd0;

endmodule

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - sequencer for a 16-point radix-2 SDF FFT pipeline
module fft_seq_ctrl #(
  parameter int LOG2N    = fft_pkg::LOG2N,
  parameter int MULT_LAT = fft_pkg::MULT_LAT,
  parameter int TOT_LAT  = fft_pkg::TOT_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ce,
  output logic [3:0]  bf_en,
  output logic [11:0] tw_idx,
  output logic        out_valid,
  output logic [3:0]  out_bin,
  output logic        frame_done
);

  import fft_pkg::*;

  localparam int DW = $clog2(TOT_LAT);

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         in_cnt;
  logic [3:0]         out_cnt;
  logic [DW-1:0]      drn_cnt;
  logic [TOT_LAT-1:0] tok_sr;
  logic [3:0]         act;
  logic               accept;

  // Gating with rst keeps ce and stage 0 quiet while reset is held.
  assign in_ready = (state != DRAIN);
  assign accept   = in_valid & in_ready & ~rst;
  assign ce       = (state == DRAIN) | accept;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (!in_valid && in_cnt == 4'd0) state_nxt = DRAIN;
      DRAIN:   if (drn_cnt == DW'(TOT_LAT - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      drn_cnt <= '0;
      tok_sr  <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + 4'd1;
      if (out_valid) out_cnt <= out_cnt + 4'd1;
      if (state == DRAIN && state_nxt == DRAIN) drn_cnt <= drn_cnt + 1'b1;
      else drn_cnt <= '0;
      if (ce) tok_sr <= {tok_sr[TOT_LAT-2:0], accept};
    end
  end

  for (genvar s = 0; s < 4; s++) begin : g_stage
    localparam int OFF = stage_off(s, LOG2N, MULT_LAT);
    if (OFF == 0) begin : g_first
      assign act[s] = accept;
    end else begin : g_tap
      assign act[s] = tok_sr[OFF-1];
    end
    fft_stage_cnt #(.STAGE(s)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .active (act[s]),
      .bf_en  (bf_en[s]),
      .tw_idx (tw_idx[3*s+2:3*s])
    );
  end

  assign out_valid  = tok_sr[TOT_LAT-1] & ce;
  assign out_bin    = {out_cnt[0], out_cnt[1], out_cnt[2], out_cnt[3]};
  assign frame_done = out_valid & (out_cnt == 4'd15);

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameters SHALL be exactly the following three.
- LOG2N, 4: FFT size exponent; N=16, 4 radix-2 SDF stages.
- MULT_LAT, 2: register latency of each stage's twiddle multiplier.
- TOT_LAT, 23: sum over s of ((N>>(s+1)) + MULT_LAT), in ce cycles.
REQ-002 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.
REQ-003 Ports SHALL be exactly the following ten.
- clk       in   1   clock
- rst       in   1   async active-high reset
- in_valid  in   1   upstream sample present
- in_ready  out  1   sample accepted when in_valid&in_ready
- ce        out  1   datapath clock-enable (all stages advance)
- bf_en     out  4   bf_en[s]=1: stage s butterfly add/sub; 0: delay-line fill/bypass
- tw_idx    out  12  3 bits per stage s at [3s+2:3s]; W16^k index for stage s multiplier
- out_valid out  1   datapath output sample valid this cycle
- out_bin   out  4   natural-order bin number of current output (bit-reversed counter)
- frame_done out 1   one-cycle pulse with last output bin of a frame

Function
REQ-004 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-005 In IDLE and RUN, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0.
REQ-006 Samples SHALL be counted by in_cnt[3:0], which increments on each accepted sample and wraps 15->0.
REQ-007 IDLE SHALL go to RUN on an accepted sample.
REQ-008 In RUN, in_valid=0 with in_cnt!=0 SHALL stall: ce=0, all counters held.
REQ-009 In RUN, in_valid=0 with in_cnt==0 (frame boundary) SHALL go to DRAIN.
REQ-010 In RUN, back-to-back frames (in_valid=1 at a boundary) SHALL stay in RUN with no bubble.
REQ-011 Outside DRAIN, ce SHALL equal in_valid&in_ready; in DRAIN, ce SHALL be 1.
REQ-012 DRAIN SHALL last exactly TOT_LAT cycles, then go to IDLE.
REQ-013 A valid-token shift register of depth TOT_LAT SHALL shift only when ce=1, with input = (accepted sample).
REQ-014 Stage s SHALL be active when the token tap at offset sum over j<s of ((8>>j)+MULT_LAT) is 1.
REQ-015 Stage s SHALL own a 4-bit counter c_s that increments on ce while active and wraps.
REQ-016 bf_en[s] SHALL equal c_s[3-s] while stage s is active, else 0.
REQ-017 For s=0..2, tw_idx[s] SHALL be (c_s mod (8>>s))<<s when stage s is active and bf_en[s]=0, else 0.
REQ-018 tw_idx[3] SHALL be 0 at all times (W^0).
REQ-019 out_valid SHALL be the final token tap AND ce.
REQ-020 out_bin SHALL be the bit-reverse of a 4-bit output counter that increments on each out_valid.
REQ-021 frame_done SHALL be 1 when out_valid=1 and the output counter equals 15.
REQ-022 Latency SHALL be TOT_LAT ce cycles: sample 0 accepted to out_valid with out_bin=0.

Reset
REQ-023 rst SHALL force: state IDLE, all counters 0, token register cleared.
REQ-024 Outputs during rst SHALL be in_ready=1, ce=0, bf_en=0, tw_idx=0, out_valid=0, out_bin=0, frame_done=0.
REQ-025 rst asserted mid-frame or mid-drain SHALL abort the frame; no partial outputs SHALL follow after release.

Structure
REQ-026 Package fft_pkg SHALL hold LOG2N, N, MULT_LAT, TOT_LAT, per-stage offset/delay constants and the state enum.
REQ-027 Sub-module fft_stage_cnt (one per stage: c_s, bf_en, tw_idx) SHALL be instantiated 4 times.

Verification
REQ-028 Reset then 16 samples with in_valid continuous -> out_valid first at ce cycle 23; out_bin sequence 0,8,4,12,2,...,15; frame_done pulses on the 16th output; state passes through DRAIN to IDLE.
REQ-029 Two frames back-to-back (32 continuous samples) -> 32 outputs contiguous, frame_done twice, no DRAIN between frames.
REQ-030 in_valid dropped for 5 cycles after sample 6 -> ce=0 for 5 cycles; bf_en/tw_idx frozen; output bin order unchanged; latency +5 clk.
REQ-031 Stage 0 during sample indices 0-7 -> bf_en[0]=0 and tw_idx[0]=index; indices 8-15 -> bf_en[0]=1, tw_idx[0]=0. Stage 2 tw_idx[2] -> values 0,4 only.
REQ-032 in_valid asserted during DRAIN -> in_ready=0, sample not accepted; after 23 drain cycles, IDLE accepts it.
REQ-033 rst pulsed at sample 10 -> all outputs 0 immediately; after release no out_valid until a new frame has been fed for 23 ce cycles.
